mux_n_pipe: RTL and testbench
=============================

// Module: mux_n_pipe
// PURPOSE
//  Parametrised N-input, WIDTH-bit word selector with a registered, valid/ready output stage.
//  Generalises the 2:1 datapath select to NUM_IN inputs.
//  A 2-entry skid buffer gives full throughput with no combinational ready path.
//  Used where select results cross a pipeline stage boundary, e.g. operand/writeback selection.
// PARAMETERS
//  WIDTH    32    data word width in bits (>=1)
//  NUM_IN   4     number of input words (>=1)
//  SEL_W    (NUM_IN>1)?$clog2(NUM_IN):1    select width; derived, do not override
// PORTS
//  i_clk      in   1             clock, rising edge
//  i_rst      in   1             synchronous, active-high reset
//  i_in       in   NUM_IN*WIDTH  packed inputs; word k = i_in[k*WIDTH +: WIDTH]
//  i_sel      in   SEL_W         index of word to forward
//  i_valid    in   1             upstream beat valid
//  o_ready    out  1             block can accept a beat this cycle
//  o_out      out  WIDTH         selected word of head beat
//  o_sel_err  out  1             head beat had i_sel >= NUM_IN
//  o_valid    out  1             head beat valid
//  i_ready    in   1             downstream accepts head beat
// BEHAVIOUR
//  - One clock (i_clk); reset is synchronous and active-high (i_rst); all state updates on rising i_clk.
//  - accept = i_valid & o_ready; take = o_valid & i_ready.
//  - Captured beat: word = i_in[i_sel*WIDTH +: WIDTH] and err = 0 if i_sel < NUM_IN; else word = 0 and err = 1.
//  - Storage: MAIN reg (drives o_out/o_sel_err) + SKID reg; FSM states EMPTY, ONE, TWO.
//  - o_valid = (state != EMPTY); o_ready = (state != TWO) & !i_rst; both depend only on state (no i_ready->o_ready path).
//  - EMPTY: accept -> MAIN<=beat, ONE.
//  - ONE: accept&take -> MAIN<=beat, stay ONE.
//    accept&!take -> SKID<=beat, TWO.
//    !accept&take -> EMPTY.
//    Neither -> hold.
//  - TWO: take -> MAIN<=SKID, ONE; otherwise hold. No accept possible.
//  - Latency: beat accepted at edge N is presented on o_out from edge N onward (visible cycle N+1).
//  - Throughput: 1 beat/cycle with i_ready held high; no bubbles.
//  - Ordering strictly FIFO; no beat lost or duplicated.
//  - o_out/o_sel_err stable while o_valid & !i_ready.
//  - i_in/i_sel ignored when accept = 0.
//  - Reset (at any state, incl. mid-stall in TWO): state <= EMPTY, MAIN and SKID <= 0.
//    o_valid = 0, o_out = 0, o_sel_err = 0, o_ready = 0 while i_rst high; o_ready = 1 the cycle after release.
//    In-flight beats discarded.
//  - NUM_IN=1: i_sel=0 selects i_in; i_sel=1 flags o_sel_err.
//  - Non-power-of-2 NUM_IN: every unused index yields word 0 with err = 1; no X propagation.
// TESTING
//  1 Reset: i_rst=1 for 2 cycles with i_valid=1 -> o_valid=0, o_out=0, o_ready=0; cycle after release o_ready=1.
//  2 Stream: NUM_IN=4, words 0x11111111/0x22222222/0x33333333/0x44444444, i_sel=0,1,2,3 back-to-back, i_ready=1
//    -> o_out 0x11111111..0x44444444 on consecutive cycles, each 1 cycle after accept, o_valid never drops.
//  3 Backpressure: i_ready=0, offer beats sel=0,1,2 -> first two accepted, o_ready=0 after 2nd, o_out holds 0x11111111;
//    raise i_ready -> 0x11111111, 0x22222222, 0x33333333 in order, no loss/duplication.
//  4 Bad select: NUM_IN=3, i_sel=3 -> o_out=0, o_sel_err=1 for that beat only; neighbouring beats err=0.
//  5 Reset in TWO: fill both entries with i_ready=0, pulse i_rst -> o_valid=0;
//    next beat sel=2 emerges as 0x33333333 with no stale data.
//  6 Random: random i_valid/i_ready/i_sel, 10k beats, scoreboard vs reference queue
//    -> all beats match in order; o_ready never high in TWO.

Source files
------------

// File: rtl/mux_n_pipe_if.sv
// Valid/ready select bus: upstream words and select in, registered head beat out.
interface mux_n_pipe_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4
);
    localparam int unsigned SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [NUM_IN*WIDTH-1:0] i_in;
    logic [SEL_W-1:0]        i_sel;
    logic                    i_valid;
    logic                    o_ready;
    logic [WIDTH-1:0]        o_out;
    logic                    o_sel_err;
    logic                    o_valid;
    logic                    i_ready;

    // Producer/consumer side: drives words, select and both handshake inputs.
    modport master (
        output i_in, i_sel, i_valid, i_ready,
        input  o_ready, o_out, o_sel_err, o_valid
    );

    // Selector side.
    modport slave (
        input  i_in, i_sel, i_valid, i_ready,
        output o_ready, o_out, o_sel_err, o_valid
    );
endinterface

// File: rtl/mux_n_pipe.sv
// N-input word selector feeding a 2-entry skid buffer (MAIN + SKID).
// Ready depends only on the state register, so there is no i_ready -> o_ready path.
module mux_n_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    mux_n_pipe_if.slave   bus
);
    localparam int unsigned SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    // Bit 0 = head valid, bit 1 = skid occupied.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_TWO   = 2'b11;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] main_word;
    logic             main_err;
    logic [WIDTH-1:0] skid_word;
    logic             skid_err;
    logic [WIDTH-1:0] beat_word;
    logic             beat_err;
    logic             accept;
    logic             take;
    logic             load_main_beat;
    logic             load_main_skid;
    logic             load_skid;

    assign bus.o_valid   = state[0];
    assign bus.o_ready   = ~state[1] & ~i_rst;
    assign bus.o_out     = main_word;
    assign bus.o_sel_err = main_err;

    assign accept = bus.i_valid & bus.o_ready;
    assign take   = bus.o_valid & bus.i_ready;

    // Word select; any index outside 0..NUM_IN-1 yields zero with the error flag set.
    always_comb begin
        beat_word = '0;
        beat_err  = 1'b1;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (bus.i_sel == SEL_W'(k)) begin
                beat_word = bus.i_in[k*WIDTH +: WIDTH];
                beat_err  = 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and storage load strobes.
    always_comb begin
        state_nxt      = state;
        load_main_beat = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    load_main_beat = 1'b1;
                    state_nxt      = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && take) begin
                    load_main_beat = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = ST_TWO;
                end else if (take) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (take) begin
                    load_main_skid = 1'b1;
                    state_nxt      = ST_ONE;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    // MAIN holds the head beat; it refills from SKID when the head drains out of TWO.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            main_word <= '0;
            main_err  <= 1'b0;
        end else if (load_main_beat) begin
            main_word <= beat_word;
            main_err  <= beat_err;
        end else if (load_main_skid) begin
            main_word <= skid_word;
            main_err  <= skid_err;
        end
    end

    // SKID catches the beat accepted while the head is stalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            skid_word <= '0;
            skid_err  <= 1'b0;
        end else if (load_skid) begin
            skid_word <= beat_word;
            skid_err  <= beat_err;
        end
    end
endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: a 4-input and a 3-input instance share one stimulus stream,
// each checked every cycle against a depth-2 FIFO reference queue.
module tb_mux_n_pipe;
    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] words [4];
    logic [1:0]       sel;
    logic             valid;
    logic             rdy;

    int n_checks;
    int n_pass;
    int n_acc;

    logic [WIDTH:0] q4 [$];
    logic [WIDTH:0] q3 [$];

    always #5 clk = ~clk;

    mux_n_pipe_if #(.WIDTH(WIDTH), .NUM_IN(4)) bus4 ();
    mux_n_pipe_if #(.WIDTH(WIDTH), .NUM_IN(3)) bus3 ();

    assign bus4.i_in    = {words[3], words[2], words[1], words[0]};
    assign bus4.i_sel   = sel;
    assign bus4.i_valid = valid;
    assign bus4.i_ready = rdy;
    assign bus3.i_in    = {words[2], words[1], words[0]};
    assign bus3.i_sel   = sel;
    assign bus3.i_valid = valid;
    assign bus3.i_ready = rdy;

    mux_n_pipe #(.WIDTH(WIDTH), .NUM_IN(4)) u_dut4 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus4)
    );

    mux_n_pipe #(.WIDTH(WIDTH), .NUM_IN(3)) u_dut3 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected captured beat {err, word} for an n-input selector.
    function automatic logic [WIDTH:0] ref_beat(input int unsigned n, input logic [1:0] s);
        if (32'(s) < n) begin
            return {1'b0, words[s]};
        end
        return {1'b1, WIDTH'(0)};
    endfunction

    task automatic check_dut(input string tag, input logic v, input logic r,
                             input logic [WIDTH-1:0] o, input logic e,
                             input int sz, input logic [WIDTH:0] head);
        check({tag, " o_valid"}, 64'(v), 64'(sz != 0));
        check({tag, " o_ready"}, 64'(r), 64'(!rst && sz < 2));
        if (sz != 0) begin
            check({tag, " o_out"}, 64'(o), 64'(head[WIDTH-1:0]));
            check({tag, " o_sel_err"}, 64'(e), 64'(head[WIDTH]));
        end
    endtask

    // One clock: check mid-cycle, advance the reference at the edge, return just after it.
    task automatic cycle();
        logic           acc4;
        logic           acc3;
        logic           tk4;
        logic           tk3;
        logic [WIDTH:0] b4;
        logic [WIDTH:0] b3;
        @(negedge clk);
        check_dut("dut4", bus4.o_valid, bus4.o_ready, bus4.o_out, bus4.o_sel_err,
                  q4.size(), (q4.size() != 0) ? q4[0] : '0);
        check_dut("dut3", bus3.o_valid, bus3.o_ready, bus3.o_out, bus3.o_sel_err,
                  q3.size(), (q3.size() != 0) ? q3[0] : '0);
        acc4 = valid && !rst && (q4.size() < 2);
        acc3 = valid && !rst && (q3.size() < 2);
        tk4  = rdy && (q4.size() != 0);
        tk3  = rdy && (q3.size() != 0);
        b4   = ref_beat(4, sel);
        b3   = ref_beat(3, sel);
        @(posedge clk);
        if (rst) begin
            q4.delete();
            q3.delete();
        end else begin
            if (tk4) void'(q4.pop_front());
            if (acc4) q4.push_back(b4);
            if (tk3) void'(q3.pop_front());
            if (acc3) q3.push_back(b3);
            if (acc4) n_acc++;
        end
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_acc    = 0;
        words[0] = 32'h1111_1111;
        words[1] = 32'h2222_2222;
        words[2] = 32'h3333_3333;
        words[3] = 32'h4444_4444;
        rst      = 1'b1;
        valid    = 1'b1;
        rdy      = 1'b0;
        sel      = 2'd0;
        @(posedge clk);
        #1;

        // Reset held with valid offered
        cycle();
        cycle();
        check("rst o_out", 64'(bus4.o_out), 64'h0);
        check("rst o_valid", 64'(bus4.o_valid), 64'h0);
        check("rst o_ready", 64'(bus4.o_ready), 64'h0);
        rst   = 1'b0;
        valid = 1'b0;
        cycle();
        check("release o_ready", 64'(bus4.o_ready), 64'h1);

        // Back-to-back stream
        rdy   = 1'b1;
        valid = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            cycle();
            check("stream o_out", 64'(bus4.o_out), 64'(words[s]));
            check("stream o_valid", 64'(bus4.o_valid), 64'h1);
        end
        valid = 1'b0;
        cycle();
        check("stream drained", 64'(bus4.o_valid), 64'h0);

        // Backpressure into the skid entry
        rdy   = 1'b0;
        valid = 1'b1;
        sel   = 2'd0;
        cycle();
        sel = 2'd1;
        cycle();
        check("bp full o_ready", 64'(bus4.o_ready), 64'h0);
        check("bp full o_out", 64'(bus4.o_out), 64'h1111_1111);
        sel = 2'd2;
        cycle();
        check("bp stall o_out", 64'(bus4.o_out), 64'h1111_1111);
        rdy = 1'b1;
        cycle();
        check("bp drain 2nd", 64'(bus4.o_out), 64'h2222_2222);
        cycle();
        check("bp drain 3rd", 64'(bus4.o_out), 64'h3333_3333);
        valid = 1'b0;
        cycle();
        check("bp empty", 64'(bus4.o_valid), 64'h0);

        // Out-of-range select on the 3-input instance
        valid = 1'b1;
        sel   = 2'd2;
        cycle();
        check("badsel pre err", 64'(bus3.o_sel_err), 64'h0);
        sel = 2'd3;
        cycle();
        check("badsel o_out", 64'(bus3.o_out), 64'h0);
        check("badsel err", 64'(bus3.o_sel_err), 64'h1);
        check("sel3 on 4-in", 64'(bus4.o_out), 64'h4444_4444);
        sel = 2'd0;
        cycle();
        check("badsel post out", 64'(bus3.o_out), 64'h1111_1111);
        check("badsel post err", 64'(bus3.o_sel_err), 64'h0);
        valid = 1'b0;
        cycle();

        // Reset while both entries are full
        rdy   = 1'b0;
        valid = 1'b1;
        sel   = 2'd0;
        cycle();
        sel = 2'd1;
        cycle();
        rst = 1'b1;
        cycle();
        check("rst2 o_valid", 64'(bus4.o_valid), 64'h0);
        check("rst2 o_out", 64'(bus4.o_out), 64'h0);
        rst   = 1'b0;
        valid = 1'b0;
        cycle();
        check("rst2 o_ready", 64'(bus4.o_ready), 64'h1);
        valid = 1'b1;
        sel   = 2'd2;
        rdy   = 1'b1;
        cycle();
        check("rst2 fresh o_out", 64'(bus4.o_out), 64'h3333_3333);
        check("rst2 fresh err", 64'(bus4.o_sel_err), 64'h0);
        valid = 1'b0;
        cycle();

        // Random traffic until 10k beats accepted or the cycle budget runs out
        n_acc = 0;
        for (int c = 0; c < 60000 && n_acc < 10000; c++) begin
            for (int k = 0; k < 4; k++) words[k] = $urandom;
            sel   = 2'($urandom_range(3, 0));
            valid = ($urandom_range(3, 0) != 0);
            rdy   = ($urandom_range(3, 0) != 0);
            cycle();
        end
        check("random beat budget", 64'(n_acc >= 10000), 64'h1);
        valid = 1'b0;
        rdy   = 1'b1;
        for (int c = 0; c < 3; c++) cycle();
        check("random drained 4", 64'(bus4.o_valid), 64'h0);
        check("random drained 3", 64'(bus3.o_valid), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
